// File: rtl/bus_arbiter_mp.sv
// bus_arbiter_mp: shares one slave bus between up to four masters.
// A master wins in IDLE (fixed priority or round-robin). Its payload then
// follows to an address-decoded slave while BUSY. An unmapped address gets
// a one-cycle ERROR completion, and a slave that never answers is cut off
// by an 8-bit timeout.
module bus_arbiter_mp #(
  parameter int                          NUM_MASTERS    = 2,
  parameter int                          NUM_SLAVES     = 8,
  parameter logic [32*NUM_SLAVES-1:0]    SLAVE_BASE     = '0,
  parameter logic [32*NUM_SLAVES-1:0]    SLAVE_MASK     = '0,
  parameter int                          ARB_MODE       = 1,
  parameter int                          TIMEOUT_CYCLES = 255
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_MASTERS-1:0]         m_valid,
  input  logic [32*NUM_MASTERS-1:0]      m_address,
  input  logic [32*NUM_MASTERS-1:0]      m_write_data,
  input  logic [2*NUM_MASTERS-1:0]       m_reqw,
  input  logic [2*NUM_MASTERS-1:0]       m_mode,
  input  logic [NUM_MASTERS-1:0]         m_reqs,
  output logic [NUM_MASTERS-1:0]         m_ready,
  output logic [NUM_MASTERS-1:0]         m_error,
  output logic [31:0]                    m_read_data,
  output logic [31:0]                    s_address,
  output logic [31:0]                    s_write_data,
  output logic [1:0]                     s_reqw,
  output logic [1:0]                     s_mode,
  output logic                           s_reqs,
  output logic [NUM_SLAVES-1:0]          s_select,
  input  logic [32*NUM_SLAVES-1:0]       s_read_data,
  input  logic [NUM_SLAVES-1:0]          s_ready,
  output logic [1:0]                     grant_id,
  output logic                           busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  state_t                 state_r;
  logic [1:0]             grant_r;
  logic [1:0]             last_grant_r;
  logic [7:0]             tcnt_r;

  logic [1:0]             win_s;
  logic [31:0]            win_addr_s;
  logic                   win_hit_s;
  logic [NUM_MASTERS-1:0] gnt_oh_s;
  logic [31:0]            g_addr_s;
  logic [31:0]            g_wdata_s;
  logic [1:0]             g_reqw_s;
  logic [1:0]             g_mode_s;
  logic                   g_reqs_s;
  logic [NUM_SLAVES-1:0]  g_sel_s;
  logic [31:0]            g_rdata_s;
  logic                   g_ready_s;
  logic                   timeout_s;

  // Address decode. The first matching region wins, so overlaps still give a one-hot or zero result.
  function automatic logic [NUM_SLAVES-1:0] decode_f(input logic [31:0] addr);
    logic [NUM_SLAVES-1:0] sel;
    logic                  found;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (!found && ((addr & SLAVE_MASK[32*k +: 32]) == SLAVE_BASE[32*k +: 32])) begin
        sel[k] = 1'b1;
        found  = 1'b1;
      end else begin
        sel[k] = 1'b0;
      end
    end
    return sel;
  endfunction

  // Winner selection. Fixed mode scans upward from 0. Round-robin scans upward from last+1, wrapping.
  function automatic logic [1:0] pick_f(input logic [NUM_MASTERS-1:0] req,
                                        input logic [1:0]             last);
    logic [1:0]             pick;
    logic                   found;
    logic [NUM_MASTERS-1:0] req_sh;
    int                     idx;
    pick  = 2'd0;
    found = 1'b0;
    for (int off = 1; off <= NUM_MASTERS; off++) begin
      if (ARB_MODE == 0) begin
        idx = off - 1;
      end else begin
        idx = (int'(last) + off) % NUM_MASTERS;
      end
      req_sh = req >> idx;
      if (!found && req_sh[0]) begin
        pick  = 2'(idx);
        found = 1'b1;
      end else begin
        pick  = pick;
      end
    end
    return pick;
  endfunction

  assign win_s     = pick_f(m_valid, last_grant_r);
  assign win_hit_s = |decode_f(win_addr_s);
  assign g_sel_s   = decode_f(g_addr_s);
  assign g_ready_s = |(g_sel_s & s_ready);
  assign timeout_s = (tcnt_r == 8'(TIMEOUT_CYCLES));
  assign busy      = (state_r != ST_IDLE);
  assign grant_id  = grant_r;

  // Select the arbitration winner's address and the granted master's payload.
  always_comb begin
    win_addr_s = 32'd0;
    gnt_oh_s   = '0;
    g_addr_s   = 32'd0;
    g_wdata_s  = 32'd0;
    g_reqw_s   = 2'd0;
    g_mode_s   = 2'd0;
    g_reqs_s   = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      gnt_oh_s[i] = (grant_r == 2'(i));
      win_addr_s  = (win_s == 2'(i)) ? m_address[32*i +: 32]    : win_addr_s;
      g_addr_s    = gnt_oh_s[i]      ? m_address[32*i +: 32]    : g_addr_s;
      g_wdata_s   = gnt_oh_s[i]      ? m_write_data[32*i +: 32] : g_wdata_s;
      g_reqw_s    = gnt_oh_s[i]      ? m_reqw[2*i +: 2]         : g_reqw_s;
      g_mode_s    = gnt_oh_s[i]      ? m_mode[2*i +: 2]         : g_mode_s;
      g_reqs_s    = gnt_oh_s[i]      ? m_reqs[i]                : g_reqs_s;
    end
  end

  // Mux the read data of the selected slave.
  always_comb begin
    g_rdata_s = 32'd0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      g_rdata_s = g_sel_s[k] ? s_read_data[32*k +: 32] : g_rdata_s;
    end
  end

  // Drive the slave-side payload in BUSY, and the completion strobes in BUSY and ERROR.
  always_comb begin
    m_ready      = '0;
    m_error      = '0;
    m_read_data  = 32'd0;
    s_address    = 32'd0;
    s_write_data = 32'd0;
    s_reqw       = 2'd0;
    s_mode       = 2'd0;
    s_reqs       = 1'b0;
    s_select     = '0;
    case (state_r)
      ST_BUSY: begin
        s_address    = g_addr_s;
        s_write_data = g_wdata_s;
        s_reqw       = g_reqw_s;
        s_mode       = g_mode_s;
        s_reqs       = g_reqs_s;
        s_select     = g_sel_s;
        if (g_ready_s) begin
          m_ready     = gnt_oh_s;
          m_read_data = g_rdata_s;
        end else if (timeout_s) begin
          m_ready = gnt_oh_s;
          m_error = gnt_oh_s;
        end else begin
          m_ready = '0;
        end
      end
      ST_ERROR: begin
        m_ready = gnt_oh_s;
        m_error = gnt_oh_s;
      end
      default: begin
        m_ready = '0;
      end
    endcase
  end

  // Control FSM: grant in IDLE, wait in BUSY for the slave or the timeout, and spend one cycle in ERROR.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      grant_r      <= 2'd0;
      last_grant_r <= 2'(NUM_MASTERS - 1);
      tcnt_r       <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (|m_valid) begin
            grant_r      <= win_s;
            last_grant_r <= win_s;
            tcnt_r       <= 8'd0;
            state_r      <= win_hit_s ? ST_BUSY : ST_ERROR;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (g_ready_s || timeout_s) begin
            state_r <= ST_IDLE;
            grant_r <= 2'd0;
            tcnt_r  <= 8'd0;
          end else begin
            tcnt_r  <= tcnt_r + 8'd1;
          end
        end
        ST_ERROR: begin
          state_r <= ST_IDLE;
          grant_r <= 2'd0;
        end
        default: begin
          state_r <= ST_IDLE;
          grant_r <= 2'd0;
          tcnt_r  <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter_mp.sv
// Self-checking bench for bus_arbiter_mp. It runs a vector table of one-cycle
// transactions, hand sequences for timeout and async reset, and a randomized
// transaction stream. A transaction-level reference model checks the stream.
module tb_bus_arbiter_mp;
  localparam int NM  = 3;
  localparam int NS  = 4;
  localparam int TMO = 4;
  localparam logic [32*NS-1:0] BASE_P = {32'h0000_4000, 32'h0000_4000, 32'h0000_3000, 32'h0000_1000};
  localparam logic [32*NS-1:0] MASK_P = {32'hFFFF_C000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000};
  localparam logic [32*NS-1:0] SDAT_P = {32'hD3D3_D3D3, 32'hC2C2_C2C2, 32'hB1B1_B1B1, 32'hA0A0_A0A0};

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NM-1:0]     m_valid;
  logic [32*NM-1:0]  m_address, m_write_data;
  logic [2*NM-1:0]   m_reqw, m_mode;
  logic [NM-1:0]     m_reqs;
  logic [32*NS-1:0]  s_read_data;
  logic [NS-1:0]     s_ready;
  logic [NM-1:0]     m_ready, m_error, fp_m_ready, fp_m_error;
  logic [31:0]       m_read_data, s_address, s_write_data;
  logic [31:0]       fp_m_read_data, fp_s_address, fp_s_write_data;
  logic [1:0]        s_reqw, s_mode, fp_s_reqw, fp_s_mode, grant_id, fp_grant_id;
  logic              s_reqs, fp_s_reqs, busy, fp_busy;
  logic [NS-1:0]     s_select, fp_s_select;

  int n_checks = 0;
  int n_pass   = 0;

  logic [NM-1:0] pend_v;
  logic [31:0]   pend_a [NM];
  logic [31:0]   pend_wd[NM];
  logic [1:0]    pend_w [NM];
  logic [1:0]    pend_md[NM];
  logic          pend_s [NM];

  typedef struct {
    logic [2:0]  valid;
    logic [31:0] a0, a1, a2;
    int          gnt;
    int          fp_gnt;
    logic [3:0]  sel;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  bus_arbiter_mp #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .SLAVE_BASE(BASE_P), .SLAVE_MASK(MASK_P),
                   .ARB_MODE(1), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .m_valid(m_valid), .m_address(m_address),
    .m_write_data(m_write_data), .m_reqw(m_reqw), .m_mode(m_mode), .m_reqs(m_reqs),
    .m_ready(m_ready), .m_error(m_error), .m_read_data(m_read_data),
    .s_address(s_address), .s_write_data(s_write_data), .s_reqw(s_reqw), .s_mode(s_mode),
    .s_reqs(s_reqs), .s_select(s_select), .s_read_data(s_read_data), .s_ready(s_ready),
    .grant_id(grant_id), .busy(busy));

  bus_arbiter_mp #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .SLAVE_BASE(BASE_P), .SLAVE_MASK(MASK_P),
                   .ARB_MODE(0), .TIMEOUT_CYCLES(TMO)) dut_fp (
    .clk(clk), .reset_n(reset_n), .m_valid(m_valid), .m_address(m_address),
    .m_write_data(m_write_data), .m_reqw(m_reqw), .m_mode(m_mode), .m_reqs(m_reqs),
    .m_ready(fp_m_ready), .m_error(fp_m_error), .m_read_data(fp_m_read_data),
    .s_address(fp_s_address), .s_write_data(fp_s_write_data), .s_reqw(fp_s_reqw),
    .s_mode(fp_s_mode), .s_reqs(fp_s_reqs), .s_select(fp_s_select),
    .s_read_data(s_read_data), .s_ready(s_ready), .grant_id(fp_grant_id), .busy(fp_busy));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Reference decode: the lowest region whose masked address equals its base, or -1.
  function automatic int ref_slave(input logic [31:0] addr);
    for (int k = 0; k < NS; k++)
      if ((addr & MASK_P[32*k +: 32]) == BASE_P[32*k +: 32]) return k;
    return -1;
  endfunction

  // Reference round-robin: the first requester after 'last' in circular order.
  function automatic int ref_rr(input logic [NM-1:0] req, input int last);
    for (int off = 1; off <= NM; off++) begin
      int c;
      c = (last + off) % NM;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] lo;
    lo = 32'($urandom_range(0, 4095));
    case ($urandom_range(0, 5))
      0:       return 32'h0000_1000 | lo;
      1:       return 32'h0000_3000 | lo;
      2:       return 32'h0000_4000 | lo;
      3:       return 32'h0000_5000 | lo;
      4:       return 32'hFFFF_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_req(input int i);
    pend_v[i]  = ($urandom_range(0, 3) != 0);
    pend_a[i]  = rand_addr();
    pend_wd[i] = $urandom;
    pend_w[i]  = 2'($urandom_range(0, 2));
    pend_md[i] = 2'($urandom);
    pend_s[i]  = 1'($urandom);
  endtask

  task automatic drive_masters(input logic [NM-1:0] v);
    for (int i = 0; i < NM; i++) begin
      m_address[32*i +: 32]    = pend_a[i];
      m_write_data[32*i +: 32] = pend_wd[i];
      m_reqw[2*i +: 2]         = pend_w[i];
      m_mode[2*i +: 2]         = pend_md[i];
      m_reqs[i]                = pend_s[i];
    end
    m_valid = v;
  endtask

  // Compare every output of the round-robin instance against the expectation for one cycle.
  task automatic chk_cycle(input string tag, input logic e_busy, input int g, input logic [NS-1:0] e_sel,
                           input logic e_rdy, input logic e_err, input logic chk_rd, input logic [31:0] e_rd);
    logic [NM-1:0] oh;
    logic [31:0]   e_addr, e_wd;
    logic [4:0]    e_ctrl;
    oh = e_rdy ? (NM'(1) << g) : '0;
    if (e_sel != '0) begin
      e_addr = pend_a[g];
      e_wd   = pend_wd[g];
      e_ctrl = {pend_w[g], pend_md[g], pend_s[g]};
    end else begin
      e_addr = 32'd0;
      e_wd   = 32'd0;
      e_ctrl = 5'd0;
    end
    chk({tag, " busy"},         32'(busy),     32'(e_busy));
    chk({tag, " grant_id"},     32'(grant_id), e_busy ? 32'(g) : 32'd0);
    chk({tag, " s_select"},     32'(s_select), 32'(e_sel));
    chk({tag, " m_ready"},      32'(m_ready),  32'(oh));
    chk({tag, " m_error"},      32'(m_error),  e_err ? 32'(oh) : 32'd0);
    if (chk_rd) chk({tag, " m_read_data"}, m_read_data, e_rd);
    chk({tag, " s_address"},    s_address,     e_addr);
    chk({tag, " s_write_data"}, s_write_data,  e_wd);
    chk({tag, " s_ctrl"},       32'({s_reqw, s_mode, s_reqs}), 32'(e_ctrl));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    drive_masters(3'b111);
    s_ready = '1;
    repeat (2) @(negedge clk);
    #1;
    chk_cycle("in reset", 1'b0, 0, '0, 1'b0, 1'b0, 1'b1, 32'd0);
    m_valid = '0;
    reset_n = 1'b1;
  endtask

  initial begin
    vec_t vecs[9];
    int   r_last;

    vecs[0] = '{3'b001, 32'h0000_3004, 32'h0, 32'h0, 0, 0, 4'b0010, 1'b0, 32'hB1B1_B1B1};
    vecs[1] = '{3'b011, 32'h0000_1000, 32'h0000_4010, 32'h0, 1, 0, 4'b0100, 1'b0, 32'hC2C2_C2C2};
    vecs[2] = '{3'b011, 32'h0000_1000, 32'h0000_4010, 32'h0, 0, 0, 4'b0001, 1'b0, 32'hA0A0_A0A0};
    vecs[3] = '{3'b011, 32'h0000_1000, 32'h0000_4010, 32'h0, 1, 0, 4'b0100, 1'b0, 32'hC2C2_C2C2};
    vecs[4] = '{3'b010, 32'h0000_1000, 32'hFFFF_0000, 32'h0, 1, 1, 4'b0000, 1'b1, 32'h0};
    vecs[5] = '{3'b111, 32'h0000_1000, 32'h0000_4010, 32'h0000_5008, 2, 0, 4'b1000, 1'b0, 32'hD3D3_D3D3};
    vecs[6] = '{3'b111, 32'h0000_1000, 32'h0000_4010, 32'h0000_5008, 0, 0, 4'b0001, 1'b0, 32'hA0A0_A0A0};
    vecs[7] = '{3'b100, 32'h0000_1000, 32'h0000_4010, 32'h0000_2000, 2, 2, 4'b0000, 1'b1, 32'h0};
    vecs[8] = '{3'b101, 32'h0000_3FFC, 32'h0000_4010, 32'h0000_1000, 0, 0, 4'b0010, 1'b0, 32'hB1B1_B1B1};

    reset_n = 1'b0;
    pend_v  = '0;
    for (int i = 0; i < NM; i++) begin
      pend_a[i]  = 32'd0;
      pend_wd[i] = 32'hCAFE_0000 + 32'(i);
      pend_w[i]  = 2'(i);
      pend_md[i] = 2'(i + 1);
      pend_s[i]  = (i == 1);
    end
    drive_masters('0);
    s_read_data = SDAT_P;
    s_ready     = '0;

    // Table: one-cycle transactions, with all slaves ready.
    do_reset();
    for (int v = 0; v < 9; v++) begin
      int fs;
      logic [NM-1:0] foh;
      pend_a[0] = vecs[v].a0;
      pend_a[1] = vecs[v].a1;
      pend_a[2] = vecs[v].a2;
      s_ready   = '1;
      @(negedge clk);
      drive_masters(vecs[v].valid);
      #1;
      chk_cycle("tbl idle", 1'b0, 0, '0, 1'b0, 1'b0, 1'b0, 32'd0);
      @(negedge clk);
      #1;
      chk_cycle("tbl xfer", 1'b1, vecs[v].gnt, vecs[v].sel, 1'b1, vecs[v].err, 1'b1, vecs[v].rdata);
      fs  = ref_slave(pend_a[vecs[v].fp_gnt]);
      foh = NM'(1) << vecs[v].fp_gnt;
      chk("fp grant_id",     32'(fp_grant_id),  32'(vecs[v].fp_gnt));
      chk("fp busy",         32'(fp_busy),      32'd1);
      chk("fp m_ready",      32'(fp_m_ready),   32'(foh));
      chk("fp m_error",      32'(fp_m_error),   (fs < 0) ? 32'(foh) : 32'd0);
      chk("fp s_select",     32'(fp_s_select),  (fs < 0) ? 32'd0 : (32'd1 << fs));
      chk("fp m_read_data",  fp_m_read_data,    (fs < 0) ? 32'd0 : SDAT_P[32*fs +: 32]);
      chk("fp s_address",    fp_s_address,      (fs < 0) ? 32'd0 : pend_a[vecs[v].fp_gnt]);
      chk("fp s_write_data", fp_s_write_data,   (fs < 0) ? 32'd0 : pend_wd[vecs[v].fp_gnt]);
      chk("fp s_ctrl", 32'({fp_s_reqw, fp_s_mode, fp_s_reqs}), (fs < 0) ? 32'd0 :
          32'({pend_w[vecs[v].fp_gnt], pend_md[vecs[v].fp_gnt], pend_s[vecs[v].fp_gnt]}));
    end

    // Timeout: the silent slave errors on BUSY cycle 5. Then s_ready on that same cycle wins.
    do_reset();
    pend_a[0] = 32'h0000_1000;
    for (int run = 0; run < 2; run++) begin
      s_ready = '0;
      @(negedge clk);
      drive_masters(3'b001);
      #1;
      chk_cycle("tmo idle", 1'b0, 0, '0, 1'b0, 1'b0, 1'b0, 32'd0);
      for (int c = 1; c <= TMO + 1; c++) begin
        @(negedge clk);
        s_ready = (run == 1 && c == TMO + 1) ? 4'b0001 : 4'b0000;
        #1;
        if (c <= TMO)       chk_cycle("tmo wait", 1'b1, 0, 4'b0001, 1'b0, 1'b0, 1'b0, 32'd0);
        else if (run == 0)  chk_cycle("tmo expire", 1'b1, 0, 4'b0001, 1'b1, 1'b1, 1'b0, 32'd0);
        else                chk_cycle("tmo race", 1'b1, 0, 4'b0001, 1'b1, 1'b0, 1'b1, 32'hA0A0_A0A0);
      end
      @(negedge clk);
      m_valid = '0;
      #1;
      chk_cycle("tmo back idle", 1'b0, 0, '0, 1'b0, 1'b0, 1'b0, 32'd0);
    end

    // Async reset in BUSY cycle 2 drops master 1's transfer. Afterwards master 0 wins first.
    pend_a[0] = 32'h0000_1000;
    pend_a[1] = 32'h0000_3000;
    s_ready   = '0;
    @(negedge clk);
    drive_masters(3'b011);
    #1;
    chk_cycle("arst idle", 1'b0, 0, '0, 1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    #1;
    chk_cycle("arst busy1", 1'b1, 1, 4'b0010, 1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    #1;
    chk_cycle("arst busy2", 1'b1, 1, 4'b0010, 1'b0, 1'b0, 1'b0, 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_cycle("arst async", 1'b0, 0, '0, 1'b0, 1'b0, 1'b1, 32'd0);
    s_ready = '1;
    @(negedge clk);
    #1;
    chk_cycle("arst held", 1'b0, 0, '0, 1'b0, 1'b0, 1'b1, 32'd0);
    reset_n = 1'b1;
    #1;
    chk_cycle("arst released", 1'b0, 0, '0, 1'b0, 1'b0, 1'b1, 32'd0);
    @(negedge clk);
    #1;
    chk_cycle("arst first win", 1'b1, 0, 4'b0001, 1'b1, 1'b0, 1'b1, 32'hA0A0_A0A0);

    // Randomized transaction stream against the reference model.
    do_reset();
    r_last = NM - 1;
    pend_v = '0;
    for (int t = 0; t < 300; t++) begin
      int w, sel, lat;
      logic [NS-1:0] sel_oh;
      for (int i = 0; i < NM; i++)
        if (!pend_v[i] && $urandom_range(0, 1) == 1) rand_req(i);
      while (pend_v == '0) rand_req(int'($urandom_range(0, NM - 1)));
      w   = ref_rr(pend_v, r_last);
      sel = ref_slave(pend_a[w]);
      lat = int'($urandom_range(0, 6));
      for (int k = 0; k < NS; k++) s_read_data[32*k +: 32] = $urandom;
      @(negedge clk);
      drive_masters(pend_v);
      s_ready = 4'($urandom);
      #1;
      chk_cycle("rand idle", 1'b0, 0, '0, 1'b0, 1'b0, 1'b0, 32'd0);
      if (sel < 0) begin
        @(negedge clk);
        s_ready = 4'($urandom);
        #1;
        chk_cycle("rand unmapped", 1'b1, w, '0, 1'b1, 1'b1, 1'b1, 32'd0);
      end else begin
        sel_oh = NS'(1) << sel;
        for (int c = 1; c <= TMO + 1; c++) begin
          logic [NS-1:0] rdy;
          @(negedge clk);
          if (c > 1 && $urandom_range(0, 3) == 0) m_valid[w] = 1'b0;
          rdy      = 4'($urandom);
          rdy[sel] = (c == lat + 1);
          s_ready  = rdy;
          #1;
          if (c == lat + 1) begin
            chk_cycle("rand done", 1'b1, w, sel_oh, 1'b1, 1'b0, 1'b1, s_read_data[32*sel +: 32]);
            break;
          end else if (c == TMO + 1) begin
            chk_cycle("rand timeout", 1'b1, w, sel_oh, 1'b1, 1'b1, 1'b0, 32'd0);
          end else begin
            chk_cycle("rand wait", 1'b1, w, sel_oh, 1'b0, 1'b0, 1'b0, 32'd0);
          end
        end
      end
      r_last = w;
      rand_req(w);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_mp.md
BUS_ARBITER_MP -- requirements
Module: bus_arbiter_mp

Interface
REQ-001 Parameter NUM_MASTERS, default 2: number of bus masters, legal 2..4.
REQ-002 Parameter NUM_SLAVES, default 8: number of decoded slave regions, legal 1..16.
REQ-003 Parameter SLAVE_BASE, default all zero: NUM_SLAVES x 32-bit concatenated region base addresses, slave 0 in the LSBs.
REQ-004 Parameter SLAVE_MASK, default all zero: NUM_SLAVES x 32-bit concatenated masks; slave k hits when (addr & mask_k) == base_k.
REQ-005 Parameter ARB_MODE, default 1: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-006 Parameter TIMEOUT_CYCLES, default 255: maximum BUSY cycles before error completion, legal 1..255.
REQ-007 Clock is clk and reset is reset_n; one clock, reset asynchronous and active-low.
REQ-008 clk  in  1  system clock, all state on rising edge.
REQ-009 reset_n  in  1  asynchronous active-low reset.
REQ-010 m_valid  in  NUM_MASTERS  per-master request.
REQ-011 m_address  in  32*NUM_MASTERS  per-master address.
REQ-012 m_write_data  in  32*NUM_MASTERS  per-master write data.
REQ-013 m_reqw  in  2*NUM_MASTERS  per-master access width (byte/half/word).
REQ-014 m_mode  in  2*NUM_MASTERS  per-master access mode.
REQ-015 m_reqs  in  NUM_MASTERS  per-master sign-extend flag.
REQ-016 m_ready  out  NUM_MASTERS  one-cycle completion strobe.
REQ-017 m_error  out  NUM_MASTERS  completion is an error (unmapped or timeout), valid with m_ready.
REQ-018 m_read_data  out  32  read data, broadcast to all masters, valid with m_ready.
REQ-019 s_address, s_write_data  out  32 each  payload of the granted master.
REQ-020 s_reqw, s_mode  out  2 each; s_reqs  out  1: payload of the granted master.
REQ-021 s_select  out  NUM_SLAVES  one-hot slave select.
REQ-022 s_read_data  in  32*NUM_SLAVES  per-slave read data.
REQ-023 s_ready  in  NUM_SLAVES  per-slave completion.
REQ-024 grant_id  out  2  index of the granted master, 0 when IDLE; busy  out  1  high in BUSY or ERROR.

Function
REQ-025 FSM states SHALL be IDLE, BUSY and ERROR.
REQ-026 In IDLE with any m_valid set, the arbiter SHALL pick a winner, register grant_id and go to BUSY if the winner's address hits a slave, otherwise go to ERROR.
REQ-027 Round-robin SHALL search from index (last_grant+1) mod NUM_MASTERS upward, and last_grant SHALL update on every grant.
REQ-028 Fixed priority SHALL always pick the lowest asserted index.
REQ-029 Overlapping regions: the lowest slave index SHALL win, so s_select is always one-hot or zero.
REQ-030 In BUSY, s_* payload and s_select SHALL follow the granted master combinationally; when not BUSY, all s_* outputs and s_select SHALL be 0.
REQ-031 In BUSY with s_ready[sel]=1, m_ready[g]=1, m_error[g]=0 and m_read_data=s_read_data[sel] SHALL hold in the same cycle, and the next state SHALL be IDLE.
REQ-032 ERROR SHALL last one cycle with m_ready[g]=1, m_error[g]=1 and m_read_data=0, then return to IDLE.
REQ-033 The 8-bit timeout counter SHALL clear on entry to BUSY and increment each BUSY cycle without s_ready; at count==TIMEOUT_CYCLES it SHALL complete with m_ready[g]=1 and m_error[g]=1, then go to IDLE.
REQ-034 s_ready and timeout in the same cycle: s_ready SHALL win (normal completion).
REQ-035 Masters SHALL hold m_valid and the payload until m_ready, and a master dropping m_valid mid-BUSY SHALL NOT abort the transaction.
REQ-036 IDLE SHALL always last at least one cycle, giving a minimum of 2 cycles per transaction.
REQ-037 s_ready from a non-selected slave SHALL be ignored.
REQ-038 m_ready and m_error SHALL be 0 for all non-granted masters and 0 outside completion cycles.

Reset
REQ-039 On reset_n=0, the FSM SHALL go to IDLE, and last_grant=NUM_MASTERS-1 (so master 0 wins first), timeout counter=0 and grant_id=0 immediately, without waiting for clk.
REQ-040 During and directly after reset, m_ready, m_error, m_read_data, s_select, busy and all s_* outputs SHALL be 0.
REQ-041 Reset asserted mid-BUSY SHALL drop the transaction with no m_ready pulse.

Verification
REQ-042 Single master 0 reads 0x3004, slave 1 (base 0x3000, mask 0xFFFFF000) with s_ready=1 -> s_select=0b10 in cycle 1, m_ready[0]=1 and m_read_data=s_read_data[1] in cycle 1, IDLE in cycle 2.
REQ-043 ARB_MODE=1, masters 0 and 1 requesting continuously -> grants alternate 0,1,0,1; ARB_MODE=0 -> master 0 is always granted.
REQ-044 Master 1 addresses unmapped 0xFFFF0000 -> one ERROR cycle with m_ready[1]=1, m_error[1]=1 and m_read_data=0.
REQ-045 TIMEOUT_CYCLES=4 with s_ready held 0 -> m_error pulses on the 5th BUSY cycle, then IDLE; s_ready arriving on that same cycle -> normal completion.
REQ-046 reset_n pulsed low in BUSY cycle 2 -> all outputs are 0 asynchronously and there is no m_ready pulse; after release, master 0 wins first.
REQ-047 Two slaves overlapping at 0x4000 -> only the lower index is selected.
